zaman_kontrol: RTL and testbench

ZAMAN_KONTROL -- requirements
Module: zaman_kontrol

---
 rtl/zaman_kontrol.sv | 265 ++++++++++++++++++++++++++
 tb/tb_zaman_kontrol.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/zaman_kontrol.sv
`default_nettype none
// ============================================================================
//  Module      : zaman_kontrol
//  Description : Clock-setting controller. Three raw push-buttons are
//                synchronized and debounced; the mode button steps a
//                CALIS -> DAKIKA_AYAR -> SAAT_AYAR -> CALIS state machine.
//                In CALIS a prescaler drives a 0..59 seconds counter and
//                emits a one-cycle pulse per elapsed minute. In the set modes
//                the seconds are frozen at 0 and the adjust buttons produce
//                one-cycle minute/hour adjust pulses.
//  Optional    : define OTO_TEKRAR_EN to enable auto-repeat of a held
//                adjust button every TEKRAR_CNT cycles.
//  Ports       : clk            - clock, rising edge
//                reset          - asynchronous, active-high reset
//                mod_buton      - raw mode button
//                arttir_in      - raw increment button
//                azalt_in       - raw decrement button
//                stop           - high while in a set mode
//                dakika_arttir  - one-cycle pulse per elapsed minute
//                arttir_dk/azalt_dk - minute adjust pulses
//                arttir_st/azalt_st - hour adjust pulses
//                saniye[5:0]    - seconds 0..59
//                mod[1:0]       - state (0 CALIS, 1 DAKIKA_AYAR, 2 SAAT_AYAR)
//  Revision    : 1.0 - initial release
// ============================================================================
module zaman_kontrol #(
    parameter int CLK_HZ     = 100000000,
    parameter int DEB_CNT    = 1000000,
    parameter int TEKRAR_CNT = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mod_buton,
    input  logic       arttir_in,
    input  logic       azalt_in,
    output logic       stop,
    output logic       dakika_arttir,
    output logic       arttir_dk,
    output logic       azalt_dk,
    output logic       arttir_st,
    output logic       azalt_st,
    output logic [5:0] saniye,
    output logic [1:0] mod
);

    localparam int c_PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int c_DEB_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(CLK_HZ - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        CALIS       = 2'd0,
        DAKIKA_AYAR = 2'd1,
        SAAT_AYAR   = 2'd2
    } state_t;

    // Button index: 0 = mode, 1 = increment, 2 = decrement
    logic [2:0] w_raw;
    logic [2:0] w_lvl;
    logic [2:0] w_press;

    assign w_raw = {azalt_in, arttir_in, mod_buton};

    // ------------------------------------------------------------------------
    // Per-button 2-flop synchronizer, debouncer and rising-edge detector.
    // The clean level only follows the synchronized input after it has
    // differed for DEB_CNT consecutive cycles; any bounce restarts the count.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_btn
            logic               r_s1;
            logic               r_s2;
            logic               r_lvl;
            logic               r_lvl_q;
            logic [c_DEB_W-1:0] r_cnt;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_s1    <= 1'b0;
                    r_s2    <= 1'b0;
                    r_lvl   <= 1'b0;
                    r_lvl_q <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_s1    <= w_raw[gi];
                    r_s2    <= r_s1;
                    r_lvl_q <= r_lvl;
                    if (r_s2 != r_lvl) begin
                        if (r_cnt == c_DEB_LAST) begin
                            r_lvl <= r_s2;
                            r_cnt <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else begin
                        r_cnt <= '0;
                    end
                end
            end

            assign w_lvl[gi]   = r_lvl;
            assign w_press[gi] = r_lvl & ~r_lvl_q;
        end
    endgenerate

    state_t r_state;
    state_t w_state_next;
    logic   w_mod_evt;
    logic   w_rep;
    logic   w_adj_art;
    logic   w_adj_az;
    logic   w_art_dk;
    logic   w_az_dk;
    logic   w_art_st;
    logic   w_az_st;

    assign w_mod_evt = w_press[0];

    // ------------------------------------------------------------------------
    // Auto-repeat: while exactly one adjust level is held in a set mode, a
    // repeat request fires every TEKRAR_CNT cycles counted from the press.
    // ------------------------------------------------------------------------
`ifdef OTO_TEKRAR_EN
    localparam int c_TEK_W = (TEKRAR_CNT > 1) ? $clog2(TEKRAR_CNT) : 1;
    localparam logic [c_TEK_W-1:0] c_TEK_LAST = c_TEK_W'(TEKRAR_CNT - 1);

    logic               w_hold;
    logic [c_TEK_W-1:0] r_tek_cnt;

    assign w_hold = (r_state != CALIS) && (w_lvl[1] ^ w_lvl[2]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tek_cnt <= '0;
        end else if (!w_hold || w_press[1] || w_press[2] || w_mod_evt) begin
            r_tek_cnt <= '0;
        end else if (r_tek_cnt == c_TEK_LAST) begin
            r_tek_cnt <= '0;
        end else begin
            r_tek_cnt <= r_tek_cnt + 1'b1;
        end
    end

    assign w_rep = w_hold && !(w_press[1] || w_press[2]) && (r_tek_cnt == c_TEK_LAST);
`else
    // Repeat disabled; the parameter is only referenced to keep the
    // interface identical across builds. Always evaluates to 0.
    assign w_rep = (TEKRAR_CNT < 0);
`endif

    // An adjust request needs the other adjust level to be low, so pressing
    // both buttons together yields nothing.
    assign w_adj_art = (w_press[1] | w_rep) & w_lvl[1] & ~w_lvl[2];
    assign w_adj_az  = (w_press[2] | w_rep) & w_lvl[2] & ~w_lvl[1];

    // ------------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= CALIS;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A mode event takes priority: adjust requests in that cycle are dropped.
    always_comb begin
        w_state_next = r_state;
        w_art_dk     = 1'b0;
        w_az_dk      = 1'b0;
        w_art_st     = 1'b0;
        w_az_st      = 1'b0;
        case (r_state)
            CALIS: begin
                if (w_mod_evt) begin
                    w_state_next = DAKIKA_AYAR;
                end
            end
            DAKIKA_AYAR: begin
                if (w_mod_evt) begin
                    w_state_next = SAAT_AYAR;
                end else begin
                    w_art_dk = w_adj_art;
                    w_az_dk  = w_adj_az;
                end
            end
            SAAT_AYAR: begin
                if (w_mod_evt) begin
                    w_state_next = CALIS;
                end else begin
                    w_art_st = w_adj_art;
                    w_az_st  = w_adj_az;
                end
            end
            default: begin
                w_state_next = CALIS;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Timebase: runs only while staying in CALIS. Leaving CALIS, being in a
    // set mode, or the edge that returns to CALIS all hold it at zero, so
    // counting restarts from 0 and no minute pulse can occur with stop high.
    // ------------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_presc;
    logic [5:0]         r_saniye;
    logic               r_dakika;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_saniye <= 6'd0;
            r_dakika <= 1'b0;
        end else begin
            r_dakika <= 1'b0;
            if ((r_state != CALIS) || (w_state_next != CALIS)) begin
                r_presc  <= '0;
                r_saniye <= 6'd0;
            end else if (r_presc == c_PRE_LAST) begin
                r_presc <= '0;
                if (r_saniye == 6'd59) begin
                    r_saniye <= 6'd0;
                    r_dakika <= 1'b1;
                end else begin
                    r_saniye <= r_saniye + 6'd1;
                end
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Registered adjust pulses
    logic r_art_dk;
    logic r_az_dk;
    logic r_art_st;
    logic r_az_st;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_art_dk <= 1'b0;
            r_az_dk  <= 1'b0;
            r_art_st <= 1'b0;
            r_az_st  <= 1'b0;
        end else begin
            r_art_dk <= w_art_dk;
            r_az_dk  <= w_az_dk;
            r_art_st <= w_art_st;
            r_az_st  <= w_az_st;
        end
    end

    assign stop          = (r_state != CALIS);
    assign mod           = r_state;
    assign saniye        = r_saniye;
    assign dakika_arttir = r_dakika;
    assign arttir_dk     = r_art_dk;
    assign azalt_dk      = r_az_dk;
    assign arttir_st     = r_art_st;
    assign azalt_st      = r_az_st;

endmodule
`default_nettype wire

// File: tb/tb_zaman_kontrol.sv
`default_nettype none
// ============================================================================
//  Module      : tb_zaman_kontrol
//  Description : Self-checking bench for zaman_kontrol. Stimulus pushes the
//                expected pulse (kind + cycle) into a queue; a monitor pops
//                and compares whenever any pulse output is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zaman_kontrol;

    logic       clk;
    logic       reset;
    logic       mod_buton;
    logic       arttir_in;
    logic       azalt_in;
    logic       stop;
    logic       dakika_arttir;
    logic       arttir_dk;
    logic       azalt_dk;
    logic       arttir_st;
    logic       azalt_st;
    logic [5:0] saniye;
    logic [1:0] mod;

    zaman_kontrol #(
        .CLK_HZ     (10),
        .DEB_CNT    (4),
        .TEKRAR_CNT (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mod_buton     (mod_buton),
        .arttir_in     (arttir_in),
        .azalt_in      (azalt_in),
        .stop          (stop),
        .dakika_arttir (dakika_arttir),
        .arttir_dk     (arttir_dk),
        .azalt_dk      (azalt_dk),
        .arttir_st     (arttir_st),
        .azalt_st      (azalt_st),
        .saniye        (saniye),
        .mod           (mod)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse kinds: 0 dakika_arttir, 1 arttir_dk, 2 azalt_dk, 3 arttir_st, 4 azalt_st
    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   n_total;
    int   n_pass;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input int act, input int req);
        n_total++;
        if (act == req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endfunction

    function automatic void push_exp(input int kind, input int at);
        exp_t e;
        e.kind = kind;
        e.cyc  = at;
        exp_q.push_back(e);
    endfunction

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    int   m_n;
    int   m_kind;
    exp_t m_e;

    always @(negedge clk) begin
        m_n = int'(dakika_arttir) + int'(arttir_dk) + int'(azalt_dk)
            + int'(arttir_st) + int'(azalt_st);
        if (m_n > 0) begin
            if (dakika_arttir)      m_kind = 0;
            else if (arttir_dk)     m_kind = 1;
            else if (azalt_dk)      m_kind = 2;
            else if (arttir_st)     m_kind = 3;
            else                    m_kind = 4;
            if (m_n > 1) chk("pulse_onehot", m_n, 1);
            if (dakika_arttir) chk("dakika_while_stop", int'(stop), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse_kind", m_kind, -1);
            end else begin
                m_e = exp_q.pop_front();
                chk("pulse_kind", m_kind, m_e.kind);
                if (m_e.cyc >= 0) chk("pulse_cycle", cyc, m_e.cyc);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(input int b, input int hold);
        if (b == 0) mod_buton = 1'b1;
        else if (b == 1) arttir_in = 1'b1;
        else azalt_in = 1'b1;
        step(hold);
        if (b == 0) mod_buton = 1'b0;
        else if (b == 1) arttir_in = 1'b0;
        else azalt_in = 1'b0;
    endtask

    int c0;
    int m0;

    initial begin
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        mod_buton = 1'b0;
        arttir_in = 1'b0;
        azalt_in  = 1'b0;
        step(3);
        chk("reset_mod",    int'(mod), 0);
        chk("reset_stop",   int'(stop), 0);
        chk("reset_saniye", int'(saniye), 0);

        // Free-running minute: saniye = k/10, wrap and pulse on edge 600
        reset = 1'b0;
        c0    = cyc;
        push_exp(0, c0 + 600);
        for (int k = 1; k <= 600; k++) begin
            step(1);
            if ((k % 10 == 0) || (k % 10 == 9))
                chk("saniye_count", int'(saniye), (k / 10) % 60);
        end

        // Mode press at saniye 59 with prescaler at 1: mode changes 7 cycles
        // later, before the wrap would have happened
        step(591);
        chk("saniye_59", int'(saniye), 59);
        mod_buton = 1'b1;
        step(6);
        chk("mod_before_latency", int'(mod), 0);
        step(1);
        chk("mod_after_press", int'(mod), 1);
        chk("stop_set", int'(stop), 1);
        chk("saniye_cleared", int'(saniye), 0);
        step(3);
        mod_buton = 1'b0;
        step(12);
        chk("saniye_held", int'(saniye), 0);

        // Glitch of 2 cycles: no pulse
        arttir_in = 1'b1;
        step(2);
        arttir_in = 1'b0;
        step(12);

        // Held presses in DAKIKA_AYAR
        push_exp(1, cyc + 7);
        tap(1, 7);
        step(15);
        push_exp(2, cyc + 7);
        tap(2, 7);
        step(15);

        // To SAAT_AYAR
        tap(0, 10);
        step(10);
        chk("mod_saat", int'(mod), 2);
        chk("stop_saat", int'(stop), 1);
        push_exp(3, cyc + 7);
        tap(1, 7);
        step(15);
        push_exp(4, cyc + 7);
        tap(2, 7);
        step(15);

        // Both adjust buttons together: nothing
        arttir_in = 1'b1;
        azalt_in  = 1'b1;
        step(30);
        arttir_in = 1'b0;
        azalt_in  = 1'b0;
        step(15);

        // Back to CALIS, then DAKIKA_AYAR again
        tap(0, 10);
        step(10);
        chk("mod_calis", int'(mod), 0);
        chk("stop_calis", int'(stop), 0);
        tap(0, 10);
        step(10);
        chk("mod_dakika_again", int'(mod), 1);

        // Long hold: initial pulse plus repeats when enabled
        m0 = cyc;
        push_exp(1, m0 + 7);
`ifdef OTO_TEKRAR_EN
        for (int r = 1; r <= 5; r++) push_exp(1, m0 + 7 + 8 * r);
`endif
        arttir_in = 1'b1;
        step(46);
        arttir_in = 1'b0;
        step(25);

        // Reset during a debounce count
        arttir_in = 1'b1;
        step(3);
        reset = 1'b1;
        #1;
        chk("async_reset_mod",    int'(mod), 0);
        chk("async_reset_stop",   int'(stop), 0);
        chk("async_reset_saniye", int'(saniye), 0);
        chk("async_reset_pulses",
            int'({dakika_arttir, arttir_dk, azalt_dk, arttir_st, azalt_st}), 0);
        arttir_in = 1'b0;
        step(3);
        reset = 1'b0;
        step(30);
        chk("mod_after_reset", int'(mod), 0);

        chk("pending_expected", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
